// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target receiver with a CPU-readable RX FIFO.
//
// Bytes arrive on spi_cs/spi_clk/spi_mosi (MSB first, sampled on the rising
// edge). The three SPI inputs are resynchronised to clk, and each complete
// byte is pushed into an RX FIFO. The CPU reads that FIFO over a simple
// select/ready register bus.
//
// Optional feature macro: SPI_TARGET_MISO_EN. When it is defined, the block
// adds the spi_miso port, a TXDATA holding register and a TX shifter.
//
// Ports
//   clk, reset_n        system clock; asynchronous active-low reset
//   select, wstrb, addr bus request (wstrb == 0 means a read); held until ready
//   data_i              bus write data
//   ready, data_o       one-cycle acknowledge; read data is valid while ready = 1
//   spi_cs/clk/mosi     SPI link inputs, asynchronous to clk
//   spi_miso            serial data out (feature build only)
//   irq                 level interrupt: irq_en & rx_not_empty, registered
//
// Register map (selected by addr[3:2])
//   0x0 CTRL    [0] enable, [1] irq_en
//   0x4 STATUS  [0] rx_not_empty, [1] rx_full, [2] overrun (W1C),
//               [3] cs_active, [4] tx_empty
//   0x8 RXDATA  FIFO head; a read pops it
//   0xC TXDATA  TX holding byte (write only)
module spi_target #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_mosi,
`ifdef SPI_TARGET_MISO_EN
    output logic        spi_miso,
`endif
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // ---------------- input synchronisers ----------------
    // Stage [SYNC_STAGES-1] is the oldest sample. Edges are found by
    // comparing the two most downstream stages.
    logic [SYNC_STAGES-1:0] cs_s, sck_s, mosi_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_s   <= '1;
            sck_s  <= '0;
            mosi_s <= '0;
        end else begin
            cs_s   <= {cs_s[SYNC_STAGES-2:0],   spi_cs};
            sck_s  <= {sck_s[SYNC_STAGES-2:0],  spi_clk};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_bit, cs_active;
    assign sck_rise  =  sck_s[SYNC_STAGES-2] & ~sck_s[SYNC_STAGES-1];
    assign sck_fall  = ~sck_s[SYNC_STAGES-2] &  sck_s[SYNC_STAGES-1];
    assign cs_fall   = ~cs_s[SYNC_STAGES-2]  &  cs_s[SYNC_STAGES-1];
    assign cs_rise   =  cs_s[SYNC_STAGES-2]  & ~cs_s[SYNC_STAGES-1];
    // MOSI goes through the same delay as spi_clk, so it lines up with sck_rise.
    assign mosi_bit  =  mosi_s[SYNC_STAGES-2];
    assign cs_active = ~cs_s[SYNC_STAGES-1];

    // ---------------- control registers and bus decode ----------------
    logic ctrl_en, ctrl_irq_en, overrun;
    logic acc, wr, rd;
    logic [1:0] reg_sel;

    // An access takes effect in the single cycle where ready is high.
    assign acc     = select & ready;
    assign wr      = acc & (wstrb != 4'h0) & wstrb[0];
    assign rd      = acc & (wstrb == 4'h0);
    assign reg_sel = addr[3:2];

    // ---------------- receive FSM ----------------
    state_t     state, state_n;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (ctrl_en && cs_fall)  state_n = ST_SHIFT;
            ST_SHIFT: if (!ctrl_en || cs_rise) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // A byte is only pushed while the FSM stays in SHIFT. A cs rise or a
    // disable in the same cycle therefore aborts the byte.
    assign push = (state == ST_SHIFT) && (state_n == ST_SHIFT) &&
                  sck_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state != ST_SHIFT || state_n != ST_SHIFT) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shreg   <= {shreg[5:0], mosi_bit};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // ---------------- RX FIFO ----------------
    // The pointers carry one extra wrap bit, so full and empty stay distinct.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr, count;
    logic        empty, full, pop, push_ok, ovr_set;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign pop     = rd & (reg_sel == 2'd2) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (ctrl_en && push_ok) mem[wr_ptr[PW-1:0]] <= {shreg, mosi_bit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!ctrl_en) begin
            rd_ptr <= wr_ptr;                // flush
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            overrun     <= 1'b0;
            ready       <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ready <= select & ~ready;
            irq   <= ctrl_irq_en & ~empty;
            if (wr && reg_sel == 2'd0) begin
                ctrl_en     <= data_i[0];
                ctrl_irq_en <= data_i[1];
            end
            // If a set and a W1C land in the same cycle, the set wins.
            if (ovr_set)
                overrun <= 1'b1;
            else if (wr && reg_sel == 2'd1 && data_i[2])
                overrun <= 1'b0;
        end
    end

    // ---------------- optional TX path ----------------
    logic tx_empty;

`ifdef SPI_TARGET_MISO_EN
    logic [7:0] tx_hold, tx_shift;
    logic       tx_load;

    // The next byte is loaded at cs fall. It is also loaded on the falling
    // edge after the 8th rising edge (bit_cnt has wrapped to 0 by then), so
    // its MSB is already on the line before the master samples it.
    assign tx_load = ((state == ST_IDLE) && (state_n == ST_SHIFT)) ||
                     ((state == ST_SHIFT) && sck_fall && (bit_cnt == 3'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold  <= '0;
            tx_shift <= 8'hFF;
            tx_empty <= 1'b1;
        end else begin
            if (tx_load) begin
                tx_shift <= tx_empty ? 8'hFF : tx_hold;
                tx_empty <= 1'b1;
            end else if (state == ST_SHIFT && sck_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
            if (wr && reg_sel == 2'd3) begin
                tx_hold  <= data_i[7:0];
                tx_empty <= 1'b0;
            end
        end
    end

    assign spi_miso = (state == ST_SHIFT) ? tx_shift[7] : 1'b1;
`else
    assign tx_empty = 1'b1;
`endif

    // ---------------- read mux ----------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = {30'd0, ctrl_irq_en, ctrl_en};
            2'd1: rdata = {27'd0, tx_empty, cs_active, overrun, full, ~empty};
            2'd2: rdata = empty ? 32'd0 : {24'd0, mem[rd_ptr[PW-1:0]]};
            default: rdata = '0;
        endcase
    end

    assign data_o = (ready && wstrb == 4'h0) ? rdata : 32'd0;

    // Bus bits that no register uses.
    logic unused_bits;
    assign unused_bits = ^{data_i[31:3], addr[1:0]};

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        select = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [3:0]  addr = '0;
    logic [31:0] data_i = '0;
    logic        ready;
    logic [31:0] data_o;
    logic        spi_cs = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        irq;
    logic        miso_w;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_target #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .ready(ready), .data_o(data_o), .spi_cs(spi_cs),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi),
`ifdef SPI_TARGET_MISO_EN
        .spi_miso(miso_w),
`endif
        .irq(irq)
    );
`ifndef SPI_TARGET_MISO_EN
    assign miso_w = 1'b1;
`endif

    // ---------------- reference model ----------------
    // The FIFO is modelled as a byte queue; ctrl/overrun/tx_empty are plain flags.
    logic [7:0] mq[$];
    bit m_en = 0, m_ien = 0, m_ovr = 0, m_txe = 1;

    function automatic void model_push(logic [7:0] b);
        if (!m_en) return;
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
    endfunction

    function automatic logic [31:0] exp_status(bit csa);
        return {27'd0, m_txe, csa, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus ----------------
    task automatic bus_xfer(input logic [3:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        select = 1'b1; addr = a; wstrb = s; data_i = d;
        @(posedge clk); #1;
        check("ready_pulse", {31'd0, ready}, 32'd1);
        r = data_o;
        @(posedge clk); #1;
        check("ready_single", {31'd0, ready}, 32'd0);
        select = 1'b0; wstrb = '0;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(a, 4'h1, d, r);
        if (a == 4'h0) begin
            m_en = d[0]; m_ien = d[1];
            if (!m_en) mq.delete();
        end
        if (a == 4'h4 && d[2]) m_ovr = 0;
`ifdef SPI_TARGET_MISO_EN
        if (a == 4'hC) m_txe = 0;
`endif
    endtask

    task automatic chk_status(input string tag, input bit csa);
        logic [31:0] r;
        bus_xfer(4'h4, 4'h0, 32'd0, r);
        check(tag, r, exp_status(csa));
    endtask

    task automatic chk_rx(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        bus_xfer(4'h8, 4'h0, 32'd0, r);
        e = (mq.size() != 0) ? {24'd0, mq.pop_front()} : 32'd0;
        check(tag, r, e);
    endtask

    // ---------------- SPI master ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(4);
        m = miso_w;          // master samples on its rising edge
        spi_clk = 1'b1;
        wait_clk(4);
        spi_clk = 1'b0;
    endtask

    logic [7:0] miso_q[$];

    task automatic spi_frame(input logic [7:0] bytes[$], input int partial);
        logic       m;
        logic [7:0] mb;
        spi_cs = 1'b0;
        wait_clk(8);
        foreach (bytes[k]) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(bytes[k][i], m);
                mb[i] = m;
            end
            miso_q.push_back(mb);
            model_push(bytes[k]);
        end
        for (int i = 0; i < partial; i++) spi_bit(1'($urandom_range(0, 1)), m);
        wait_clk(4);
        spi_cs = 1'b1;
        wait_clk(8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  bq[$];
        logic [31:0] r;
        logic [31:0] e;
        logic        m;
        logic [7:0]  b;

        // Reset values.
        wait_clk(3);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_miso", {31'd0, miso_w}, 32'd1);
        reset_n = 1'b1;
        wait_clk(2);
        bus_xfer(4'h0, 4'h0, 32'd0, r);
        check("rst_ctrl", r, 32'd0);
        chk_status("rst_status", 1'b0);
        chk_rx("rst_rxdata");

        // A single byte.
        bus_wr(4'h0, 32'h1);
        bq = '{8'hA5};
        spi_frame(bq, 0);
        chk_status("a5_status", 1'b0);
        chk_rx("a5_rxdata");
        chk_status("a5_status_after", 1'b0);

        // irq follows irq_en & rx_not_empty.
        bus_wr(4'h0, 32'h3);
        bq = '{8'h3C};
        spi_frame(bq, 0);
        check("irq_set", {31'd0, irq}, 32'd1);
        chk_rx("irq_rx");
        @(posedge clk); #1;
        check("irq_clear", {31'd0, irq}, 32'd0);
        bus_wr(4'h0, 32'h1);

        // Overrun: 5 bytes into a 4-deep FIFO.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        spi_frame(bq, 0);
        chk_status("ovr_status", 1'b0);
        for (int i = 0; i < 4; i++) chk_rx("ovr_rx");
        chk_status("ovr_drained", 1'b0);
        bus_wr(4'h4, 32'h4);
        chk_status("ovr_w1c", 1'b0);

        // Partial byte aborted by cs rise, then a good byte realigns.
        spi_cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), m);
        chk_status("cs_active", 1'b1);
        wait_clk(4);
        spi_cs = 1'b1;
        wait_clk(8);
        bq = '{8'h81};
        spi_frame(bq, 0);
        chk_status("partial_status", 1'b0);
        chk_rx("partial_rx");

        // Empty read returns 0 without moving pointers.
        chk_rx("empty_rx");
        b = 8'($urandom);
        bq = '{b};
        spi_frame(bq, 0);
        chk_rx("after_empty_rx");

        // Pop coincident with push while full.
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        spi_frame(bq, 0);
        b = 8'($urandom);
        spi_cs = 1'b0;
        wait_clk(8);
        for (int i = 7; i >= 1; i--) spi_bit(b[i], m);
        spi_mosi = b[0];
        wait_clk(4);
        fork
            begin @(negedge clk); spi_clk = 1'b1; end
            bus_xfer(4'h8, 4'h0, 32'd0, r);
        join
        e = {24'd0, mq.pop_front()};
        check("coinc_rx", r, e);
        mq.push_back(b);
        wait_clk(4);
        spi_clk = 1'b0;
        wait_clk(4);
        spi_cs = 1'b1;
        wait_clk(8);
        chk_status("coinc_status", 1'b0);
        for (int i = 0; i < 4; i++) chk_rx("coinc_drain");

        // Disable flushes the FIFO and ignores SPI traffic.
        bq = '{8'($urandom), 8'($urandom)};
        spi_frame(bq, 0);
        bus_wr(4'h0, 32'h0);
        chk_status("dis_flush", 1'b0);
        bq = '{8'($urandom)};
        spi_frame(bq, 0);
        chk_status("dis_ignored", 1'b0);
        bus_wr(4'h0, 32'h1);
        chk_status("reen_status", 1'b0);

        // Randomised frames against the model.
        miso_q.delete();
        for (int it = 0; it < 12; it++) begin
            bq.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) bq.push_back(8'($urandom));
            spi_frame(bq, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
            check("rnd_irq", {31'd0, irq}, {31'd0, m_ien & (mq.size() != 0)});
            chk_status("rnd_status", 1'b0);
            for (int k = 0; k < $urandom_range(0, 5); k++) chk_rx("rnd_rx");
            if (m_ovr) begin
                bus_wr(4'h4, 32'h4);
                chk_status("rnd_w1c", 1'b0);
            end
            if (it == 5) bus_wr(4'h0, 32'h3);
        end
        while (mq.size() != 0) chk_rx("rnd_drain");

`ifdef SPI_TARGET_MISO_EN
        // TX holding byte goes out first, then 0xFF once it is empty.
        bus_wr(4'hC, 32'h5A);
        chk_status("tx_loaded", 1'b0);
        miso_q.delete();
        bq = '{8'($urandom), 8'($urandom)};
        spi_frame(bq, 0);
        m_txe = 1;
        check("miso_b0", {24'd0, miso_q[0]}, 32'h5A);
        check("miso_b1", {24'd0, miso_q[1]}, 32'hFF);
        chk_status("tx_empty", 1'b0);
        while (mq.size() != 0) chk_rx("tx_drain");
`endif

        // Asynchronous reset in the middle of an access, with irq high.
        bus_wr(4'h0, 32'h3);
        bq = '{8'($urandom), 8'($urandom)};
        spi_frame(bq, 0);
        spi_cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 3; i++) spi_bit(1'($urandom_range(0, 1)), m);
        @(negedge clk);
        select = 1'b1; addr = 4'h8; wstrb = 4'h0;
        @(posedge clk); #1;
        check("pre_rst_ready", {31'd0, ready}, 32'd1);
        check("pre_rst_data", data_o, {24'd0, mq[0]});
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, ready}, 32'd0);
        check("async_rst_data", data_o, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_miso", {31'd0, miso_w}, 32'd1);
        select = 1'b0;
        spi_cs = 1'b1;
        mq.delete(); m_en = 0; m_ien = 0; m_ovr = 0; m_txe = 1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        bus_xfer(4'h0, 4'h0, 32'd0, r);
        check("post_rst_ctrl", r, 32'd0);
        chk_status("post_rst_status", 1'b0);
        chk_rx("post_rst_rx");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
